cam_match_encoder: RTL and testbench
====================================

Name: cam_match_encoder

Overview:
- Sits downstream of the CAM lookup path and converts the CAM's one-hot/multi-hot match vector into a stream of binary entry indices.
- Accepts one match vector plus the searched key per lookup. Emits one index per handshake, lowest index first, with a last flag.
- Flags a miss when no entry matched and reports the hit count.
- Lets the host walk every matching entry through a narrow output.

Parameters:
- ENTRIES, 16, number of CAM entries (width of the match vector).
- IDX_W, 4, index width; must equal clog2(ENTRIES).
- KEY_W, 7, width of the searched content key carried alongside each index.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- match_valid  input  1  match vector and key are valid this cycle.
- match_ready  output  1  block can accept a new match vector.
- match_vec  input  ENTRIES  multi-hot match result; bit i set means entry i matched.
- match_key  input  KEY_W  key that produced match_vec.
- addr_valid  output  1  addr_idx/addr_key/addr_last are valid.
- addr_ready  input  1  consumer accepts the current index.
- addr_idx  output  IDX_W  binary index of the current matching entry.
- addr_key  output  KEY_W  latched key of the lookup being emitted.
- addr_last  output  1  current index is the final match of this lookup.
- miss  output  1  one-cycle pulse: accepted lookup had no matches.
- hit_count  output  IDX_W+1  popcount of the last accepted match_vec (0..ENTRIES).

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, pending vector=0, addr_valid=0, addr_idx=0, addr_key=0, addr_last=0, miss=0, hit_count=0, match_ready=1 after release.
- States: IDLE, EMIT.
- match_ready = (state==IDLE). It is never high in EMIT, including the final handshake cycle.
- IDLE, match_valid=1 (acceptance):
  - latch pending<=match_vec and addr_key<=match_key.
  - hit_count<=popcount(match_vec).
  - If match_vec==0: miss=1 for the next cycle only, stay IDLE.
  - Else: go to EMIT.
- IDLE, match_valid=0: nothing changes; match_vec/match_key are don't-care. miss returns to 0.
- EMIT:
  - addr_valid=1.
  - addr_idx = index of the lowest set bit of pending.
  - addr_last = 1 iff pending has exactly one bit set.
- Handshake (addr_valid & addr_ready): clear the lowest set bit of pending. If addr_last, go to IDLE; otherwise the next index is presented in the following cycle.
- Latency: first addr_valid appears the cycle after acceptance. With addr_ready held high, one index is emitted per cycle.
- Back-to-back lookups have one IDLE cycle between the last beat and the next acceptance.
- Backpressure: while addr_valid=1 and addr_ready=0, addr_idx, addr_key and addr_last are held stable.
- hit_count holds its value until the next acceptance. It is not decremented during emission.
- addr_key holds across the whole lookup and after it completes.
- A full vector (all ENTRIES bits set) emits ENTRIES beats; hit_count=ENTRIES, requiring IDX_W+1 bits.
- Reset mid-EMIT: addr_valid drops immediately (asynchronously) and pending is discarded. No partial beat is replayed after release.
- miss and addr_valid are never high in the same cycle.

Test Plan:
1. Single hit: match_vec=0x0010, match_key=0x2A -> next cycle addr_valid=1, addr_idx=4, addr_key=0x2A, addr_last=1, hit_count=1; one beat; match_ready=1 the cycle after the handshake.
2. Multi hit, no stall: match_vec=0x8421, addr_ready=1 -> addr_idx 0,5,10,15 on four consecutive cycles; addr_last only on 15; hit_count=4.
3. Backpressure: match_vec=0x0006, addr_ready=0 for 3 cycles, then 1 -> addr_idx=1 held stable with addr_last=0 during the stall, then idx 1 then idx 2 with addr_last=1.
4. Miss: match_vec=0x0000, match_key=0x11 -> miss high exactly one cycle, addr_valid never asserts, hit_count=0, match_ready stays 1.
5. Full match: match_vec=0xFFFF -> 16 beats, idx 0..15 in order, hit_count=16, addr_last only on idx 15.
6. Reset mid-operation: match_vec=0x00F0, rst_n=0 after beats 4 and 5 -> addr_valid=0 and hit_count=0 with no clock edge needed; after release match_ready=1 and a new lookup 0x0001 emits only idx 0.

Source files
------------

// File: rtl/cam_match_encoder_if.sv
// Match-vector input and index-stream output bundle of the CAM match encoder.
// The host drives the lookup and consumes indices; the encoder is the slave.
interface cam_match_encoder_if #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned KEY_W   = 7
);
    logic               match_valid;
    logic               match_ready;
    logic [ENTRIES-1:0] match_vec;
    logic [KEY_W-1:0]   match_key;
    logic               addr_valid;
    logic               addr_ready;
    logic [IDX_W-1:0]   addr_idx;
    logic [KEY_W-1:0]   addr_key;
    logic               addr_last;
    logic               miss;
    logic [IDX_W:0]     hit_count;

    modport master (
        output match_valid, match_vec, match_key, addr_ready,
        input  match_ready, addr_valid, addr_idx, addr_key, addr_last, miss, hit_count
    );

    modport slave (
        input  match_valid, match_vec, match_key, addr_ready,
        output match_ready, addr_valid, addr_idx, addr_key, addr_last, miss, hit_count
    );
endinterface

// File: rtl/cam_match_encoder.sv
// Turns a multi-hot CAM match vector into a lowest-first stream of binary
// entry indices with a last flag, plus miss pulse and hit count.
module cam_match_encoder #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned KEY_W   = 7
) (
    input logic                  clk,
    input logic                  rst_n,
    cam_match_encoder_if.slave   bus
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index of the lowest set bit; zero for an empty vector.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [ENTRIES-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            r = r + CNT_W'(v[i]);
        end
        return r;
    endfunction

    state_t             state, state_nxt;
    logic [ENTRIES-1:0] pending, pending_nxt;
    logic               ready_q, ready_nxt;
    logic               valid_q, valid_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [KEY_W-1:0]   key_q, key_nxt;
    logic               last_q, last_nxt;
    logic               miss_q, miss_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [CNT_W-1:0]   vec_cnt;
    logic [ENTRIES-1:0] remain;

    // Popcount of the incoming vector and the pending set minus its lowest bit.
    assign vec_cnt = popcount(bus.match_vec);
    assign remain  = pending & (pending - ENTRIES'(1));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            idx_q   <= '0;
            key_q   <= '0;
            last_q  <= 1'b0;
            miss_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            ready_q <= ready_nxt;
            valid_q <= valid_nxt;
            idx_q   <= idx_nxt;
            key_q   <= key_nxt;
            last_q  <= last_nxt;
            miss_q  <= miss_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state and next-output logic; the presented beat is precomputed so
    // addr_idx/addr_last come straight from flops.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        valid_nxt   = valid_q;
        idx_nxt     = idx_q;
        key_nxt     = key_q;
        last_nxt    = last_q;
        miss_nxt    = 1'b0;
        cnt_nxt     = cnt_q;

        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (bus.match_valid) begin
                    pending_nxt = bus.match_vec;
                    key_nxt     = bus.match_key;
                    cnt_nxt     = vec_cnt;
                    if (bus.match_vec == '0) begin
                        miss_nxt = 1'b1;
                    end else begin
                        state_nxt = EMIT;
                        valid_nxt = 1'b1;
                        idx_nxt   = lowest_idx(bus.match_vec);
                        last_nxt  = (vec_cnt == CNT_W'(1));
                    end
                end
            end
            EMIT: begin
                valid_nxt = 1'b1;
                if (bus.addr_ready) begin
                    pending_nxt = remain;
                    if (last_q) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end else begin
                        idx_nxt  = lowest_idx(remain);
                        last_nxt = (popcount(remain) == CNT_W'(1));
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = '0;
                valid_nxt   = 1'b0;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
    end

    assign bus.match_ready = ready_q;
    assign bus.addr_valid  = valid_q;
    assign bus.addr_idx    = idx_q;
    assign bus.addr_key    = key_q;
    assign bus.addr_last   = last_q;
    assign bus.miss        = miss_q;
    assign bus.hit_count   = cnt_q;

    // Invariants of the output stream.
    a_miss_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(miss_q && valid_q));
    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ready_q && valid_q));
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.addr_ready) |=>
            (valid_q && $stable(idx_q) && $stable(key_q) && $stable(last_q)));

endmodule

// File: tb/tb_cam_match_encoder.sv
// Self-checking bench for cam_match_encoder: directed table, reset corner
// and randomized lookups against a bit-walking reference model.
module tb_cam_match_encoder;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned KEY_W   = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cam_match_encoder_if #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .KEY_W(KEY_W)) bus ();

    cam_match_encoder #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .KEY_W(KEY_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] vec;
        logic [6:0]  key;
        int          stall;
        int          exp_hit;
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t tbl[5];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic rdy(input int c, input int stall, input int pct);
        if (c < stall) return 1'b0;
        return ($urandom_range(0, 99) < 32'(pct));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one lookup and follows its beats; the model lists set bits in ascending order.
    task automatic run_lookup(input logic [15:0] vec, input logic [6:0] key,
                              input int stall, input int pct,
                              output int beats, output int first_idx,
                              output int last_idx, output int cycles);
        int exp_q[$];
        int k;
        int c;
        int guard;
        for (int i = 0; i < int'(ENTRIES); i++) if (vec[i]) exp_q.push_back(i);
        beats = 0; first_idx = -1; last_idx = -1; cycles = 0;

        guard = 0;
        while (!bus.match_ready && guard < 50) begin
            step();
            guard++;
        end
        chk("ready_before_accept", 32'(bus.match_ready), 32'd1);

        bus.match_vec   = vec;
        bus.match_key   = key;
        bus.match_valid = 1'b1;
        bus.addr_ready  = rdy(0, stall, pct);
        step();
        bus.match_valid = 1'b0;
        bus.match_vec   = 16'($urandom);
        bus.match_key   = 7'($urandom);

        chk("hit_count", 32'(bus.hit_count), exp_q.size());
        if (exp_q.size() == 0) begin
            chk("miss_pulse", 32'(bus.miss), 32'd1);
            chk("miss_no_valid", 32'(bus.addr_valid), 32'd0);
            chk("miss_ready", 32'(bus.match_ready), 32'd1);
            step();
            chk("miss_clear", 32'(bus.miss), 32'd0);
            chk("miss_no_valid2", 32'(bus.addr_valid), 32'd0);
            chk("miss_hit_hold", 32'(bus.hit_count), 32'd0);
            return;
        end
        chk("no_miss", 32'(bus.miss), 32'd0);

        k = 0;
        c = 0;
        while (k < exp_q.size() && c < 300) begin
            chk("valid", 32'(bus.addr_valid), 32'd1);
            chk("ready_low_emit", 32'(bus.match_ready), 32'd0);
            chk("miss_low_emit", 32'(bus.miss), 32'd0);
            chk("idx", 32'(bus.addr_idx), exp_q[k]);
            chk("key", 32'(bus.addr_key), 32'(key));
            chk("last", 32'(bus.addr_last), 32'(k == exp_q.size() - 1));
            if (bus.addr_ready) begin
                if (k == 0) first_idx = int'(bus.addr_idx);
                last_idx = int'(bus.addr_idx);
                beats++;
                k++;
            end
            step();
            c++;
            bus.addr_ready = rdy(c, stall, pct);
        end
        chk("emit_complete", k, exp_q.size());
        cycles = c;
        chk("valid_drop", 32'(bus.addr_valid), 32'd0);
        chk("ready_after", 32'(bus.match_ready), 32'd1);
        chk("hit_hold", 32'(bus.hit_count), exp_q.size());
        chk("key_hold", 32'(bus.addr_key), 32'(key));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, first_idx, last_idx, cycles;
        logic [15:0] v;

        bus.match_valid = 1'b0;
        bus.match_vec   = '0;
        bus.match_key   = '0;
        bus.addr_ready  = 1'b0;

        tbl[0] = '{16'h0010, 7'h2A, 0,  1,  4,  4};
        tbl[1] = '{16'h8421, 7'h33, 0,  4,  0, 15};
        tbl[2] = '{16'h0006, 7'h05, 3,  2,  1,  2};
        tbl[3] = '{16'h0000, 7'h11, 0,  0, -1, -1};
        tbl[4] = '{16'hFFFF, 7'h7F, 0, 16,  0, 15};

        #12;
        chk("rst_valid", 32'(bus.addr_valid), 32'd0);
        chk("rst_miss", 32'(bus.miss), 32'd0);
        chk("rst_hit", 32'(bus.hit_count), 32'd0);
        chk("rst_idx", 32'(bus.addr_idx), 32'd0);
        chk("rst_key", 32'(bus.addr_key), 32'd0);
        chk("rst_last", 32'(bus.addr_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_ready", 32'(bus.match_ready), 32'd1);

        foreach (tbl[i]) begin
            run_lookup(tbl[i].vec, tbl[i].key, tbl[i].stall, 100,
                       beats, first_idx, last_idx, cycles);
            chk("tbl_beats", beats, tbl[i].exp_hit);
            chk("tbl_first", first_idx, tbl[i].exp_first);
            chk("tbl_last", last_idx, tbl[i].exp_last);
            chk("tbl_cycles", cycles, (tbl[i].exp_hit == 0) ? 0 : tbl[i].exp_hit + tbl[i].stall);
        end

        // Reset in the middle of a lookup, after indices 4 and 5 were taken.
        bus.match_vec   = 16'h00F0;
        bus.match_key   = 7'h4C;
        bus.match_valid = 1'b1;
        bus.addr_ready  = 1'b1;
        step();
        bus.match_valid = 1'b0;
        chk("mid_idx4", 32'(bus.addr_idx), 32'd4);
        step();
        chk("mid_idx5", 32'(bus.addr_idx), 32'd5);
        step();
        chk("mid_idx6", 32'(bus.addr_idx), 32'd6);
        chk("mid_valid", 32'(bus.addr_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_valid", 32'(bus.addr_valid), 32'd0);
        chk("async_hit", 32'(bus.hit_count), 32'd0);
        chk("async_key", 32'(bus.addr_key), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus.match_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.addr_valid), 32'd0);
        step();
        chk("post_rst_no_replay", 32'(bus.addr_valid), 32'd0);
        run_lookup(16'h0001, 7'h01, 0, 100, beats, first_idx, last_idx, cycles);
        chk("post_rst_beats", beats, 1);
        chk("post_rst_idx", first_idx, 0);

        // Randomized lookups, back to back, with random backpressure.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'(32'd1 << $urandom_range(0, 15));
                2:       v = 16'($urandom);
                default: v = 16'($urandom & $urandom);
            endcase
            run_lookup(v, 7'($urandom), int'($urandom_range(0, 2)),
                       int'($urandom_range(30, 100)), beats, first_idx, last_idx, cycles);
            chk("rnd_beats", beats, $countones(v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
